vga_timing_gen: RTL and testbench

Free-running VGA raster timing generator. Produces the pixel coordinates (DrawX, DrawY) and the visible-area flag (blank) that every sprite and palette renderer in the display path consumes. Also produces hsync and vsync, delayed to line up with the renderers' one-cycle registered RGB output, plus frame and line strobes for game-state update logic. Default timing is 640x480 @ 60 Hz from a 25 MHz vga_clk.

---
 rtl/vga_timing_gen.sv | 130 +++++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, visible flag, delayed syncs, line/frame strobes.
// Latency: DrawX/DrawY/blank/strobes are registered with no lag between them; hs/vs trail by SYNC_DELAY clocks.
// Backpressure: none; the raster advances every vga_clk cycle and consumers must keep up.
//
// Ports:
//   vga_clk      pixel clock, all logic on its rising edge
//   reset        synchronous, active-high; restarts the raster at (0,0)
//   DrawX/DrawY  current horizontal/vertical count
//   blank        1 while the current pixel is in the visible area
//   hs/vs        active-low syncs, delayed to match the renderers' registered RGB
//   line_start   one-cycle pulse when DrawX==0 (not on the reset/release cycle)
//   frame_start  one-cycle pulse when DrawX==0 and DrawY==0 (not on the reset/release cycle)
//   frame_count  completed-frame counter, wraps modulo 256
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    // Thresholds are one bit wider than the counters so a sync window ending
    // exactly at 1024 (zero back porch, maximal total) still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_BEG    = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_BEG    = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_raw_nxt;
    logic       vs_raw_nxt;

    // Stage 0 holds the raw sync aligned with DrawX/DrawY; stage SYNC_DELAY drives the pin.
    logic [SYNC_DELAY:0] hs_pipe;
    logic [SYNC_DELAY:0] vs_pipe;

    always_comb begin
        h_wrap = (hc == H_MAX);
        v_wrap = (vc == V_MAX);
        hc_nxt = h_wrap ? 10'd0 : hc + 10'd1;
        vc_nxt = vc;
        if (h_wrap) begin
            vc_nxt = v_wrap ? 10'd0 : vc + 10'd1;
        end
        hs_raw_nxt = !(({1'b0, hc_nxt} >= HS_BEG) && ({1'b0, hc_nxt} < HS_END));
        vs_raw_nxt = !(({1'b0, vc_nxt} >= VS_BEG) && ({1'b0, vc_nxt} < VS_END));
    end

    // Every registered output is derived from the next-state counters so it is
    // consistent with the DrawX/DrawY value it appears alongside.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc          <= 10'd0;
            vc          <= 10'd0;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            blank       <= ({1'b0, hc_nxt} < H_VIS_END) && ({1'b0, vc_nxt} < V_VIS_END);
            line_start  <= (hc_nxt == 10'd0);
            frame_start <= (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
            if (h_wrap && v_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // Reset fills the whole delay line with the inactive level so no partial
    // sync pulse can emerge after reset.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe <= 1'b1;
                    vs_pipe <= 1'b1;
                end else begin
                    hs_pipe <= hs_raw_nxt;
                    vs_pipe <= vs_raw_nxt;
                end
            end
        end else begin : g_delay
            always_ff @(posedge vga_clk) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe <= {hs_pipe[SYNC_DELAY-1:0], hs_raw_nxt};
                    vs_pipe <= {vs_pipe[SYNC_DELAY-1:0], vs_raw_nxt};
                end
            end
        end
    endgenerate

    assign DrawX = hc;
    assign DrawY = vc;
    assign hs    = hs_pipe[SYNC_DELAY];
    assign vs    = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic vga_clk = 1'b0;
    logic reset   = 1'b0;

    always #5 vga_clk = ~vga_clk;

    // a: default timing, delay 1; b: default timing, delay 0;
    // c: small raster (14x7), delay 1; d: small raster, delay 3
    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y, d_x, d_y;
    logic       a_bl, a_hs, a_vs, a_ls, a_fs;
    logic       b_bl, b_hs, b_vs, b_ls, b_fs;
    logic       c_bl, c_hs, c_vs, c_ls, c_fs;
    logic       d_bl, d_hs, d_vs, d_ls, d_fs;
    logic [7:0] a_fc, b_fc, c_fc, d_fc;

    vga_timing_gen u_a (
        .vga_clk(vga_clk), .reset(reset), .DrawX(a_x), .DrawY(a_y), .blank(a_bl),
        .hs(a_hs), .vs(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(0)) u_b (
        .vga_clk(vga_clk), .reset(reset), .DrawX(b_x), .DrawY(b_y), .blank(b_bl),
        .hs(b_hs), .vs(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(1)
    ) u_c (
        .vga_clk(vga_clk), .reset(reset), .DrawX(c_x), .DrawY(c_y), .blank(c_bl),
        .hs(c_hs), .vs(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(3)
    ) u_d (
        .vga_clk(vga_clk), .reset(reset), .DrawX(d_x), .DrawY(d_y), .blank(d_bl),
        .hs(d_hs), .vs(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: position on the raster is just the number of running clocks
    // since the last reset edge, folded by the line and frame lengths.
    typedef struct {
        int x; int y; int bl; int ls; int fs; int hs; int vs; int fc;
    } exp_t;

    function automatic exp_t model(input int t,
                                   input int hv, input int hf, input int hsy, input int hb,
                                   input int vv, input int vf, input int vsy, input int vb,
                                   input int dly);
        exp_t e;
        int ht, vt, p, px, py;
        ht   = hv + hf + hsy + hb;
        vt   = vv + vf + vsy + vb;
        e.x  = t % ht;
        e.y  = (t / ht) % vt;
        e.fc = (t / (ht * vt)) % 256;
        e.bl = (e.x < hv && e.y < vv) ? 1 : 0;
        e.ls = (t > 0 && e.x == 0) ? 1 : 0;
        e.fs = (e.ls == 1 && e.y == 0) ? 1 : 0;
        p = t - dly;
        if (p < 0) begin
            e.hs = 1;
            e.vs = 1;
        end else begin
            px   = p % ht;
            py   = (p / ht) % vt;
            e.hs = (px >= hv + hf && px < hv + hf + hsy) ? 0 : 1;
            e.vs = (py >= vv + vf && py < vv + vf + vsy) ? 0 : 1;
        end
        return e;
    endfunction

    task automatic check_inst(input string p, input exp_t e,
                              input int x, input int y, input int bl, input int hs,
                              input int vs, input int ls, input int fs, input int fc);
        chk({p, "_DrawX"}, x, e.x);
        chk({p, "_DrawY"}, y, e.y);
        chk({p, "_blank"}, bl, e.bl);
        chk({p, "_hs"}, hs, e.hs);
        chk({p, "_vs"}, vs, e.vs);
        chk({p, "_line_start"}, ls, e.ls);
        chk({p, "_frame_start"}, fs, e.fs);
        chk({p, "_frame_count"}, fc, e.fc);
    endtask

    int t        = 0;
    bit seen_rst = 1'b0;

    always @(posedge vga_clk) begin
        if (reset) begin
            t        <= 0;
            seen_rst <= 1'b1;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge vga_clk) begin
        if (seen_rst) begin
            check_inst("a", model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1),
                       a_x, a_y, a_bl, a_hs, a_vs, a_ls, a_fs, a_fc);
            check_inst("b", model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0),
                       b_x, b_y, b_bl, b_hs, b_vs, b_ls, b_fs, b_fc);
            check_inst("c", model(t, 8, 2, 2, 2, 4, 1, 1, 1, 1),
                       c_x, c_y, c_bl, c_hs, c_vs, c_ls, c_fs, c_fc);
            check_inst("d", model(t, 8, 2, 2, 2, 4, 1, 1, 1, 3),
                       d_x, d_y, d_bl, d_hs, d_vs, d_ls, d_fs, d_fc);
        end
    end

    task automatic do_reset(input int n);
        @(negedge vga_clk);
        reset = 1'b1;
        repeat (n) @(posedge vga_clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n, lo_cnt, lo_first, lo_last, b_cnt, b_first, b_last;
        int bl_cnt, ls_cnt, fs_cnt, hs_cnt, vs_cnt;

        do_reset(3);

        // First line_start of the default raster after release
        n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (!a_ls && n < 900);
        chk("a_first_line_start_clk", t, 800);

        // One full line of hsync for delay 1 (a) and delay 0 (b)
        lo_cnt = 0; lo_first = -1; lo_last = -1;
        b_cnt  = 0; b_first  = -1; b_last  = -1;
        for (int i = 0; i < 800; i++) begin
            if (!a_hs) begin
                lo_cnt++;
                if (lo_first < 0) lo_first = int'(a_x);
                lo_last = int'(a_x);
            end
            if (!b_hs) begin
                b_cnt++;
                if (b_first < 0) b_first = int'(b_x);
                b_last = int'(b_x);
            end
            @(negedge vga_clk);
        end
        chk("a_hs_low_cycles", lo_cnt, 96);
        chk("a_hs_first_x", lo_first, 657);
        chk("a_hs_last_x", lo_last, 752);
        chk("b_hs_low_cycles", b_cnt, 96);
        chk("b_hs_first_x", b_first, 656);
        chk("b_hs_last_x", b_last, 751);

        // Mid-line reset at DrawX=300, held 5 cycles
        n = 0;
        while (a_x != 10'd300 && n < 900) begin
            @(negedge vga_clk);
            n++;
        end
        chk("a_reached_x300", int'(a_x), 300);
        reset = 1'b1;
        @(negedge vga_clk);
        chk("rst_DrawX", int'(a_x), 0);
        chk("rst_DrawY", int'(a_y), 0);
        chk("rst_blank", int'(a_bl), 1);
        chk("rst_frame_count", int'(a_fc), 0);
        repeat (4) @(posedge vga_clk);
        #1 reset = 1'b0;

        // Reset while hsync is low must drop the pulse immediately
        n = 0;
        while (a_hs && n < 1000) begin
            @(negedge vga_clk);
            n++;
        end
        chk("a_hs_low_seen", int'(a_hs), 0);
        reset = 1'b1;
        @(negedge vga_clk);
        chk("rst_in_sync_a_hs", int'(a_hs), 1);
        chk("rst_in_sync_b_hs", int'(b_hs), 1);
        #1 reset = 1'b0;

        // Small raster: first frame_start and per-frame aggregates
        n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (!c_fs && n < 200);
        chk("c_first_frame_start_clk", t, 98);
        bl_cnt = 0; ls_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int i = 0; i < 98; i++) begin
            bl_cnt += int'(c_bl);
            ls_cnt += int'(c_ls);
            fs_cnt += int'(c_fs);
            hs_cnt += int'(!c_hs);
            vs_cnt += int'(!c_vs);
            @(negedge vga_clk);
        end
        chk("c_blank_cycles", bl_cnt, 32);
        chk("c_line_starts", ls_cnt, 7);
        chk("c_frame_starts", fs_cnt, 1);
        chk("c_hs_low_cycles", hs_cnt, 14);
        chk("c_vs_low_cycles", vs_cnt, 14);

        // frame_count wrap across 257 small frames
        do_reset(2);
        n = 0;
        while (t != 256 * 98 && n < 26000) begin
            @(negedge vga_clk);
            n++;
        end
        chk("c_fc_at_256_frames", int'(c_fc), 0);
        chk("c_fs_at_256_frames", int'(c_fs), 1);
        n = 0;
        while (t != 257 * 98 && n < 200) begin
            @(negedge vga_clk);
            n++;
        end
        chk("c_fc_at_257_frames", int'(c_fc), 1);
        chk("c_fs_at_257_frames", int'(c_fs), 1);

        // Random run lengths and reset pulses, checked by the per-cycle model
        for (int k = 0; k < 15; k++) begin
            repeat ($urandom_range(1, 2000)) @(negedge vga_clk);
            do_reset($urandom_range(1, 4));
        end
        repeat (50) @(negedge vga_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
